njp_micro_div: RTL and testbench

NJP_MICRO_DIV -- requirements
Module: njp_micro_div

---
 rtl/njp_micro_div.sv | 168 ++++++++++++++++
 tb/tb_njp_micro_div.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/njp_micro_div.sv
// ---------------------------------------------------------------------------
// njp_micro_div -- 8-bit by 4-bit unsigned restoring divider, one quotient
// bit per clock.
//
// Ports
//   sys_clk      in   1  clock, all state updates on the rising edge
//   nsys_rst     in   1  asynchronous active-low reset
//   start        in   1  request a division (sampled only in IDLE)
//   dividend     in   8  unsigned dividend, captured on accepted start
//   divisor      in   4  unsigned divisor, captured on accepted start
//   quotient     out  8  registered quotient, held until the next result
//   remainder    out  4  registered remainder, held until the next result
//   busy         out  1  high while iterating (CALC)
//   done         out  1  one-cycle result strobe (DONE)
//   div_by_zero  out  1  registered zero-divisor flag, valid with done
//
// Configuration
//   NJP_DIV_ZERO_DETECT_EN  defined: a zero divisor skips the iteration and
//                           completes in one cycle with div_by_zero set.
//                           undefined: a zero divisor runs the normal path
//                           (quotient 8'hFF, remainder dividend[3:0]) and
//                           div_by_zero is tied low.
// ---------------------------------------------------------------------------
module njp_micro_div (
  input  logic       sys_clk,
  input  logic       nsys_rst,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       busy,
  output logic       done,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] a_q, a_d;      // dividend shifting out, quotient shifting in
  logic [3:0] b_q, b_d;      // captured divisor
  logic [4:0] r_q, r_d;      // partial remainder (one spare bit for the compare)
  logic [2:0] cnt_q, cnt_d;  // step counter, wraps after the 8th step
  logic [7:0] quo_q, quo_d;
  logic [3:0] rem_q, rem_d;
`ifdef NJP_DIV_ZERO_DETECT_EN
  logic       dbz_q, dbz_d;
`endif

  // One restoring step, computed from the current registers.
  logic [4:0] r_shift, r_step;
  logic [7:0] a_shift, a_step;

  always_comb begin
    r_shift = {r_q[3:0], a_q[7]};
    a_shift = {a_q[6:0], 1'b0};
    if (r_shift >= {1'b0, b_q}) begin
      r_step = r_shift - {1'b0, b_q};
      a_step = a_shift | 8'h01;
    end else begin
      r_step = r_shift;
      a_step = a_shift;
    end
  end

  // NOTE: every signal driven here gets a hold/default value before the case
  // statement, so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
`ifdef NJP_DIV_ZERO_DETECT_EN
    dbz_d   = dbz_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = dividend;
          b_d     = divisor;
          r_d     = '0;
          cnt_d   = '0;
          state_d = CALC;
`ifdef NJP_DIV_ZERO_DETECT_EN
          // Zero divisor: publish the saturated result right away.
          if (divisor == 4'd0) begin
            state_d = DONE;
            quo_d   = 8'hFF;
            rem_d   = dividend[3:0];
            dbz_d   = 1'b1;
          end
`endif
        end
      end

      CALC: begin
        a_d   = a_step;
        r_d   = r_step;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = DONE;
          quo_d   = a_step;
          // The remainder is always below the 4-bit divisor, so bit 4 is zero.
          rem_d   = r_step[3:0];
`ifdef NJP_DIV_ZERO_DETECT_EN
          dbz_d   = 1'b0;
`endif
        end
      end

      DONE: begin
        // start is deliberately ignored here; it is honoured again in IDLE.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge sys_clk or negedge nsys_rst) begin
    if (!nsys_rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
`ifdef NJP_DIV_ZERO_DETECT_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
`ifdef NJP_DIV_ZERO_DETECT_EN
      dbz_q   <= dbz_d;
`endif
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign busy      = (state_q == CALC);
  assign done      = (state_q == DONE);
`ifdef NJP_DIV_ZERO_DETECT_EN
  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_njp_micro_div.sv
// ---------------------------------------------------------------------------
// tb_njp_micro_div -- self-checking bench for njp_micro_div.
// Expected results come from plain integer division; expected timing comes
// from the documented latency (8 busy cycles, done one cycle, back in IDLE
// the cycle after). Inputs change on the falling edge or just after the
// rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_njp_micro_div;

  logic       sys_clk;
  logic       nsys_rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int checks = 0;
  int errors = 0;

  njp_micro_div dut (
    .sys_clk     (sys_clk),
    .nsys_rst    (nsys_rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", tag, obs, exp);
    end
  endtask

  // ---- reference model -----------------------------------------------------
  function automatic logic [7:0] ref_quo(input logic [7:0] dd, input logic [3:0] dv);
    return (dv == 4'd0) ? 8'hFF : 8'(int'(dd) / int'(dv));
  endfunction

  function automatic logic [3:0] ref_rem(input logic [7:0] dd, input logic [3:0] dv);
    return (dv == 4'd0) ? dd[3:0] : 4'(int'(dd) % int'(dv));
  endfunction

  function automatic int ref_lat(input logic [3:0] dv);
`ifdef NJP_DIV_ZERO_DETECT_EN
    return (dv == 4'd0) ? 0 : 8;
`else
    return (dv == 4'd0) ? 8 : 8;
`endif
  endfunction

  function automatic logic ref_dbz(input logic [3:0] dv);
`ifdef NJP_DIV_ZERO_DETECT_EN
    return (dv == 4'd0);
`else
    return (dv == 4'd0) ? 1'b0 : 1'b0;
`endif
  endfunction

  // One complete operation. Operands are scrambled right after acceptance to
  // prove they were captured. With inject set, a second start (99/9) is
  // pulsed mid-operation and must be ignored.
  task automatic do_div(input logic [7:0] dd, input logic [3:0] dv, input bit inject,
                        input string tag);
    int  lat;
    int  nbusy;
    bit  got;
    bit  extra;
    lat   = 0;
    nbusy = 0;
    got   = 1'b0;
    extra = 1'b0;
    @(negedge sys_clk);
    start    = 1'b1;
    dividend = dd;
    divisor  = dv;
    @(posedge sys_clk);
    #1;
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) nbusy++;
      if (inject && lat == 3) begin
        start    = 1'b1;
        dividend = 8'd99;
        divisor  = 4'd9;
        @(posedge sys_clk);
        #1;
        start = 1'b0;
      end
      lat++;
    end
    check({tag, " done_seen"}, 32'(got), 32'd1);
    if (got) begin
      check({tag, " latency"},   32'(lat),         32'(ref_lat(dv)));
      check({tag, " busy_cnt"},  32'(nbusy),       32'(ref_lat(dv)));
      check({tag, " quotient"},  32'(quotient),    32'(ref_quo(dd, dv)));
      check({tag, " remainder"}, 32'(remainder),   32'(ref_rem(dd, dv)));
      check({tag, " dbz"},       32'(div_by_zero), 32'(ref_dbz(dv)));
      @(negedge sys_clk);
      check({tag, " done_1cyc"}, 32'(done),        32'd0);
      check({tag, " idle_gap"},  32'(busy),        32'd0);
      check({tag, " hold_quo"},  32'(quotient),    32'(ref_quo(dd, dv)));
      check({tag, " hold_rem"},  32'(remainder),   32'(ref_rem(dd, dv)));
    end
    if (inject) begin
      for (int i = 0; i < 12; i++) begin
        @(negedge sys_clk);
        if (done || busy) extra = 1'b1;
      end
      check({tag, " no_second_op"}, 32'(extra), 32'd0);
    end
  endtask

  initial begin
    int  last;
    int  pulses;
    bit  seen;
    logic [7:0] rdd;
    logic [3:0] rdv;

    nsys_rst = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #1;
    check("rst quotient",  32'(quotient),    32'd0);
    check("rst remainder", 32'(remainder),   32'd0);
    check("rst busy",      32'(busy),        32'd0);
    check("rst done",      32'(done),        32'd0);
    check("rst dbz",       32'(div_by_zero), 32'd0);
    repeat (3) @(negedge sys_clk);
    nsys_rst = 1'b1;

    // Directed cases.
    do_div(8'd200, 4'd7,  1'b0, "200/7");
    do_div(8'd225, 4'd15, 1'b0, "225/15");
    do_div(8'd7,   4'd9,  1'b0, "7/9");
    do_div(8'd255, 4'd1,  1'b0, "255/1");
    do_div(8'd0,   4'd5,  1'b0, "0/5");
    do_div(8'd100, 4'd0,  1'b0, "100/0");
    do_div(8'd50,  4'd3,  1'b1, "50/3 inject");

    // Reset in the middle of an operation.
    @(negedge sys_clk);
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 4'd7;
    @(posedge sys_clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge sys_clk);
    #1;
    nsys_rst = 1'b0;
    #1;
    check("abort quotient",  32'(quotient),    32'd0);
    check("abort remainder", 32'(remainder),   32'd0);
    check("abort busy",      32'(busy),        32'd0);
    check("abort done",      32'(done),        32'd0);
    check("abort dbz",       32'(div_by_zero), 32'd0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge sys_clk);
      if (done) seen = 1'b1;
    end
    check("abort no_done", 32'(seen), 32'd0);
    nsys_rst = 1'b1;
    do_div(8'd200, 4'd7, 1'b0, "200/7 post_rst");

    // start held high: a new operation every 10 cycles.
    @(negedge sys_clk);
    start    = 1'b1;
    dividend = 8'd143;
    divisor  = 4'd11;
    last     = -1;
    pulses   = 0;
    for (int c = 0; c < 45; c++) begin
      @(negedge sys_clk);
      if (done) begin
        pulses++;
        check("b2b quotient",  32'(quotient),  32'd13);
        check("b2b remainder", 32'(remainder), 32'd0);
        if (last >= 0) check("b2b period", 32'(c - last), 32'd10);
        last = c;
      end
    end
    check("b2b pulses", 32'(pulses), 32'd4);
    start = 1'b0;
    repeat (12) @(negedge sys_clk);

    // Random operands.
    for (int i = 0; i < 300; i++) begin
      rdd = 8'($urandom);
      rdv = 4'($urandom_range(0, 15));
      do_div(rdd, rdv, 1'b0, $sformatf("rand %0d/%0d", rdd, rdv));
    end

    // Exhaustive sweep of every operand pair.
    for (int d = 0; d < 256; d++) begin
      for (int v = 0; v < 16; v++) begin
        do_div(8'(d), 4'(v), 1'b0, $sformatf("sweep %0d/%0d", d, v));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
